// File: rtl/video_pattern_pkg.sv
// Shared types and helpers for the video pattern source: pattern mode enum,
// colour-bar RGB masks, timing totals and the colour-bar start-position helper.
package video_pattern_pkg;

   typedef enum logic [1:0] {
      PAT_BAR   = 2'd0,
      PAT_GRAD  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pat_mode_e;

   // Scene x coordinate width; wide enough for 4 channels of 1280 plus offsets.
   localparam int XE_W = 13;

   // Bar colours as {R,G,B} on/off masks; each bit expands to a full COMP_W
   // component in the pattern slice. Order: white, yellow, cyan, green,
   // magenta, red, blue, black.
   localparam logic [2:0] BAR_MASK [8] = '{
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

   function automatic int h_total(input int hdisp, input int hblank);
      return hdisp + hblank;
   endfunction

   function automatic int v_total(input int vsync, input int vback,
                                  input int vdisp, input int vfront);
      return vsync + vback + vdisp + vfront;
   endfunction

   // Bar index (saturating at 8 = black tail) and position inside the bar for
   // a scene x coordinate, packed as {idx[3:0], pos[12:0]}.
   function automatic logic [16:0] bar_start(input logic [XE_W-1:0] xe0,
                                             input int bar_w);
      int q;
      int r;
      q = int'(xe0) / bar_w;
      r = int'(xe0) % bar_w;
      if (q > 8) q = 8;
      return {4'(q), 13'(r)};
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing for the pattern source: pixel-slot divider, h/v counters,
// frame counter and the combinational sync/position decodes of the current
// counter state. The top registers everything it drives out.
module video_timing_gen
   import video_pattern_pkg::*;
#(
   parameter int IMG_HDISP = 1280,
   parameter int IMG_VDISP = 720,
   parameter int H_BLANK   = 160,
   parameter int V_SYNC    = 5,
   parameter int V_BACK    = 20,
   parameter int V_FRONT   = 5,
   parameter int CLK_DIV   = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        tick,
   output logic        line_end,
   output logic        frame_end,
   output logic        frame_start,
   output logic        h_act,
   output logic        vsync_c,
   output logic        href_c,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = h_total(IMG_HDISP, H_BLANK);
   localparam int V_TOTAL = v_total(V_SYNC, V_BACK, IMG_VDISP, V_FRONT);

   localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_DISP    = 12'(IMG_HDISP);
   localparam logic [11:0] V_SYNCEND = 12'(V_SYNC);
   localparam logic [11:0] V_ACT_BEG = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BACK + IMG_VDISP);
   localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);

   logic [3:0]  div_cnt;
   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic [11:0] y_full;
   logic        act_line;
   logic        unused_bits;

   // Tick marks the last clock of a pixel slot; with CLK_DIV=1 the divider
   // stays at 0 and tick is permanently high.
   assign tick = (div_cnt == DIV_LAST);

   // Slot divider: counts clocks within a slot, restarting after each tick.
   always_ff @(posedge clk) begin
      if (rst || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + 4'd1;
   end

   // Raster counters: h within a line, v within a frame, frames completed.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         frame_cnt <= '0;
      end else if (tick) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt     <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               v_cnt <= v_cnt + 12'd1;
            end
         end else begin
            h_cnt <= h_cnt + 12'd1;
         end
      end
   end

   assign line_end    = tick && (h_cnt == H_LAST);
   assign frame_end   = line_end && (v_cnt == V_LAST);
   assign frame_start = tick && (h_cnt == 12'd0) && (v_cnt == 12'd0);

   assign act_line = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
   assign h_act    = (h_cnt < H_DISP);
   assign href_c   = act_line && h_act;
   assign vsync_c  = (v_cnt < V_SYNCEND);

   assign y_full = v_cnt - V_ACT_BEG;
   assign x      = h_cnt[10:0];
   assign y      = y_full[10:0];

   assign unused_bits = ^{h_cnt[11], y_full[11]};

endmodule

// File: rtl/video_pattern_src.sv
// Multi-channel synthetic CMOS video source. NUM_CH channels view windows of
// one wide scene, offset by CH_X_OFFSET, with shared registered timing.
// Optional feature macro VIDEO_PATTERN_SRC_MOTION_EN: scrolls the scene by
// frame_cnt[7:0] pixels per frame on every channel.
module video_pattern_src
   import video_pattern_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int COMP_W      = 8,
   parameter int IMG_HDISP   = 1280,
   parameter int IMG_VDISP   = 720,
   parameter int H_BLANK     = 160,
   parameter int V_SYNC      = 5,
   parameter int V_BACK      = 20,
   parameter int V_FRONT     = 5,
   parameter int CLK_DIV     = 1,
   parameter int CH_X_OFFSET = 1024,
   parameter int CELL_LOG2   = 5
) (
   input  logic                         cmos_clk,
   input  logic                         sys_rst,
   input  logic [1:0]                   pat_mode,
   input  logic [3*COMP_W-1:0]          solid_rgb,
   output logic                         cmos_vsync,
   output logic                         cmos_href,
   output logic                         cmos_clken,
   output logic [NUM_CH*3*COMP_W-1:0]   cmos_data,
   output logic [10:0]                  x_pos,
   output logic [10:0]                  y_pos,
   output logic [15:0]                  frame_cnt
);

   localparam int PIX_W   = 3 * COMP_W;
   localparam int SCENE_W = IMG_HDISP + (NUM_CH - 1) * CH_X_OFFSET;
   localparam int BAR_W   = SCENE_W / 8;
   localparam logic [XE_W-1:0] BAR_LAST = XE_W'(BAR_W - 1);

   logic            tick;
   logic            line_end;
   logic            frame_end;
   logic            frame_start;
   logic            h_act;
   logic            vsync_c;
   logic            href_c;
   logic            clken_c;
   logic [10:0]     x_c;
   logic [10:0]     y_c;
   logic [15:0]     frame_q;
   pat_mode_e       mode_q;
   logic [PIX_W-1:0] solid_q;
   logic [XE_W-1:0] shift_cur;
   logic [XE_W-1:0] shift_nxt;
   logic [PIX_W-1:0] data_arr [NUM_CH];

   video_timing_gen #(
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP),
      .H_BLANK   (H_BLANK),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK),
      .V_FRONT   (V_FRONT),
      .CLK_DIV   (CLK_DIV)
   ) u_timing (
      .clk         (cmos_clk),
      .rst         (sys_rst),
      .tick        (tick),
      .line_end    (line_end),
      .frame_end   (frame_end),
      .frame_start (frame_start),
      .h_act       (h_act),
      .vsync_c     (vsync_c),
      .href_c      (href_c),
      .x           (x_c),
      .y           (y_c),
      .frame_cnt   (frame_q)
   );

   assign clken_c = href_c & tick;

   // Scene shift for the current counter state and for the line about to
   // start (which belongs to the next frame when the frame wraps).
`ifdef VIDEO_PATTERN_SRC_MOTION_EN
   assign shift_cur = {5'd0, frame_q[7:0]};
   assign shift_nxt = {5'd0, frame_q[7:0] + {7'd0, frame_end}};
`else
   assign shift_cur = '0;
   assign shift_nxt = '0;
`endif

   // Mode latch: pattern selection only changes at the first slot of a frame,
   // so a frame is never rendered with two patterns.
   always_ff @(posedge cmos_clk) begin
      if (sys_rst) begin
         mode_q  <= PAT_BAR;
         solid_q <= '0;
      end else if (frame_start) begin
         mode_q  <= pat_mode_e'(pat_mode);
         solid_q <= solid_rgb;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [XE_W-1:0] CH_OFF = XE_W'(c * CH_X_OFFSET);

      logic [3:0]       bar_idx;
      logic [XE_W-1:0]  bar_pos;
      logic [XE_W-1:0]  xe;
      logic [16:0]      start_rst;
      logic [16:0]      start_nxt;
      logic [2:0]       mask;
      logic [PIX_W-1:0] pix;
      logic [PIX_W-1:0] pix_q;
      logic             unused_xe;

      assign xe        = {2'b00, x_c} + CH_OFF + shift_cur;
      assign start_rst = bar_start(CH_OFF, BAR_W);
      assign start_nxt = bar_start(CH_OFF + shift_nxt, BAR_W);
      assign unused_xe = ^xe;

      // Running bar counter: preset at each line start to the channel's
      // first bar, stepped on every active pixel slot; saturates at 8 (black).
      always_ff @(posedge cmos_clk) begin
         if (sys_rst) begin
            {bar_idx, bar_pos} <= start_rst;
         end else if (line_end) begin
            {bar_idx, bar_pos} <= start_nxt;
         end else if (tick && h_act) begin
            if (bar_pos == BAR_LAST) begin
               bar_pos <= '0;
               if (bar_idx != 4'd8) bar_idx <= bar_idx + 4'd1;
            end else begin
               bar_pos <= bar_pos + 13'd1;
            end
         end
      end

      // Pixel colour for the current counter state under the latched mode.
      always_comb begin
         mask = (bar_idx < 4'd8) ? BAR_MASK[bar_idx[2:0]] : 3'b000;
         pix  = '0;
         case (mode_q)
            PAT_BAR:   pix = {{COMP_W{mask[2]}}, {COMP_W{mask[1]}}, {COMP_W{mask[0]}}};
            PAT_GRAD:  pix = {3{xe[COMP_W-1:0]}};
            PAT_CHECK: pix = {PIX_W{xe[CELL_LOG2] ^ y_c[CELL_LOG2]}};
            PAT_SOLID: pix = solid_q;
            default:   pix = '0;
         endcase
      end

      // Registered channel data, forced to zero outside the pixel strobe.
      always_ff @(posedge cmos_clk) begin
         if (sys_rst) pix_q <= '0;
         else         pix_q <= clken_c ? pix : '0;
      end

      assign data_arr[c] = pix_q;
   end

   // Pack channel slices, channel c at bits [c*PIX_W +: PIX_W].
   always_comb begin
      cmos_data = '0;
      for (int c = 0; c < NUM_CH; c++) cmos_data[c*PIX_W +: PIX_W] = data_arr[c];
   end

   // Output registers: all sync/position outputs aligned with cmos_data.
   always_ff @(posedge cmos_clk) begin
      if (sys_rst) begin
         cmos_vsync <= 1'b0;
         cmos_href  <= 1'b0;
         cmos_clken <= 1'b0;
         x_pos      <= '0;
         y_pos      <= '0;
         frame_cnt  <= '0;
      end else begin
         cmos_vsync <= vsync_c;
         cmos_href  <= href_c;
         cmos_clken <= clken_c;
         x_pos      <= href_c ? x_c : 11'd0;
         y_pos      <= href_c ? y_c : 11'd0;
         frame_cnt  <= frame_q;
      end
   end

endmodule

// File: tb/tb_video_pattern_src.sv
// Bench for video_pattern_src: two instances (CLK_DIV=1 and CLK_DIV=3) on a
// small raster, checked every cycle against a slot-index model, plus directed
// vectors with hand-computed values.
module tb_video_pattern_src;

   localparam int H_TOT  = 20;
   localparam int V_TOT  = 7;
   localparam int F_SLOT = H_TOT * V_TOT;
   localparam int VA     = 2;
   localparam int CH_OFF = 8;
`ifdef VIDEO_PATTERN_SRC_MOTION_EN
   localparam bit MOTION = 1'b1;
`else
   localparam bit MOTION = 1'b0;
`endif

   // clock / reset
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  pat_mode = 2'd1;
   logic [23:0] solid_rgb = 24'h0;
   always #5 clk = ~clk;

   logic        vs_o [2];
   logic        hr_o [2];
   logic        ck_o [2];
   logic [47:0] dat_o [2];
   logic [10:0] x_o [2];
   logic [10:0] y_o [2];
   logic [15:0] fc_o [2];

   video_pattern_src #(
      .NUM_CH(2), .COMP_W(8), .IMG_HDISP(16), .IMG_VDISP(4), .H_BLANK(4),
      .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .CLK_DIV(1), .CH_X_OFFSET(8), .CELL_LOG2(2)
   ) dut1 (
      .cmos_clk(clk), .sys_rst(rst), .pat_mode(pat_mode), .solid_rgb(solid_rgb),
      .cmos_vsync(vs_o[0]), .cmos_href(hr_o[0]), .cmos_clken(ck_o[0]),
      .cmos_data(dat_o[0]), .x_pos(x_o[0]), .y_pos(y_o[0]), .frame_cnt(fc_o[0])
   );

   video_pattern_src #(
      .NUM_CH(2), .COMP_W(8), .IMG_HDISP(16), .IMG_VDISP(4), .H_BLANK(4),
      .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .CLK_DIV(3), .CH_X_OFFSET(8), .CELL_LOG2(2)
   ) dut3 (
      .cmos_clk(clk), .sys_rst(rst), .pat_mode(pat_mode), .solid_rgb(solid_rgb),
      .cmos_vsync(vs_o[1]), .cmos_href(hr_o[1]), .cmos_clken(ck_o[1]),
      .cmos_data(dat_o[1]), .x_pos(x_o[1]), .y_pos(y_o[1]), .frame_cnt(fc_o[1])
   );

   // scoreboard state
   int          n_checks = 0;
   int          n_errors = 0;
   logic [23:0] exp_q[$];
   int          k = 0;
   int          phase = 1;
   int          mm [2];
   logic [23:0] ms [2];
   int          cnt_vs = 0;
   int          cnt_ck = 0;
   int          cnt_hr3 = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s k=%0d obs=%0h exp=%0h", tag, k, obs, exp);
      end
   endtask

   function automatic logic [23:0] pix_model(input int mode, input int c, input int x,
                                             input int y, input int f, input logic [23:0] solid);
      int xe;
      int sh;
      sh = MOTION ? (f % 256) : 0;
      xe = x + c * CH_OFF + sh;
      case (mode)
         0: begin
            case (xe / 3)
               0: return 24'hFFFFFF;
               1: return 24'hFFFF00;
               2: return 24'h00FFFF;
               3: return 24'h00FF00;
               4: return 24'hFF00FF;
               5: return 24'hFF0000;
               6: return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         1: return {3{8'(xe % 256)}};
         2: return ((((xe >> 2) ^ (y >> 2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: return solid;
      endcase
   endfunction

   // driver: advance one clock, check both instances against the model
   task automatic step();
      @(negedge clk);
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_d%0d_ctl", d), {vs_o[d], hr_o[d], ck_o[d]}, 0);
            check($sformatf("rst_d%0d_data", d), dat_o[d], 0);
            check($sformatf("rst_d%0d_pos", d), {x_o[d], y_o[d], fc_o[d]}, 0);
         end
      end else begin
         k++;
         for (int d = 0; d < 2; d++) begin
            int dv, idx, f, s, h, v;
            bit tk, e_hr, e_ck;
            logic [23:0] e_pix;
            dv   = (d == 0) ? 1 : 3;
            idx  = (k - 1) / dv;
            tk   = (((k - 1) % dv) == dv - 1);
            f    = idx / F_SLOT;
            s    = idx % F_SLOT;
            h    = s % H_TOT;
            v    = s / H_TOT;
            e_hr = (v >= VA) && (v < VA + 4) && (h < 16);
            e_ck = e_hr && tk;
            check($sformatf("d%0d_vsync", d), vs_o[d], (v < 1));
            check($sformatf("d%0d_href", d), hr_o[d], e_hr);
            check($sformatf("d%0d_clken", d), ck_o[d], e_ck);
            check($sformatf("d%0d_x", d), x_o[d], e_hr ? h : 0);
            check($sformatf("d%0d_y", d), y_o[d], e_hr ? v - VA : 0);
            check($sformatf("d%0d_frame", d), fc_o[d], f & 16'hFFFF);
            for (int c = 0; c < 2; c++) begin
               e_pix = e_ck ? pix_model(mm[d], c, h, v - VA, f, ms[d]) : 24'h0;
               if (d == 0 && c == 0) begin
                  if (e_ck) exp_q.push_back(e_pix);
                  if (ck_o[0]) begin
                     check("sb_c0_depth", exp_q.size(), 1);
                     if (exp_q.size() > 0) check("sb_c0_pix", dat_o[0][23:0], exp_q.pop_front());
                  end else begin
                     check("d0_c0_idle", dat_o[0][23:0], 0);
                  end
               end else begin
                  check($sformatf("d%0d_c%0d_pix", d, c), dat_o[d][c*24 +: 24], e_pix);
               end
            end
            if (tk && h == 0 && v == 0) begin
               mm[d] = int'(pat_mode);
               ms[d] = solid_rgb;
            end
         end
         if (phase == 1) begin
            if (k <= 140) begin
               cnt_vs += int'(vs_o[0]);
               cnt_ck += int'(ck_o[0]);
            end
            if (k >= 121 && k <= 180) cnt_hr3 += int'(hr_o[1]);
         end
      end
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   task automatic release_reset();
      rst = 1'b0;
      k = 0;
      for (int d = 0; d < 2; d++) begin
         mm[d] = 0;
         ms[d] = 24'h0;
      end
   endtask

   initial begin
      // phase 1: gradient from power-up, then bar, then solid
      rst = 1'b1;
      pat_mode = 2'd1;
      for (int i = 0; i < 3; i++) step();
      release_reset();
      run_to(46);
      check("grad_c0_x5", dat_o[0][23:0], 24'h050505);
      check("grad_c1_x5", dat_o[0][47:24], 24'h0D0D0D);
      run_to(57);
      check("blank_data", dat_o[0], 0);
      run_to(140);
      check("vsync_cycles", cnt_vs, 20);
      check("clken_pulses", cnt_ck, 64);
      check("frame_cnt_140", fc_o[0], 0);
      run_to(141);
      check("frame_cnt_141", fc_o[0], 1);
      run_to(180);
      check("div3_href_line", cnt_hr3, 48);
      run_to(210);
      pat_mode = 2'd0;
      run_to(321);
      check("bar_c0_x0", dat_o[0][23:0], 24'hFFFFFF);
      check("bar_c1_x0", dat_o[0][47:24], 24'h00FFFF);
      run_to(324);
      check("bar_c0_x3", dat_o[0][23:0], 24'hFFFF00);
      run_to(336);
      check("bar_c1_x15", dat_o[0][47:24], 24'h000000);
      check("bar_c1_x15_clken", ck_o[0], 1);
      run_to(350);
      pat_mode  = 2'd3;
      solid_rgb = 24'h123456;
      run_to(381);
      check("no_tear_c0", dat_o[0][23:0], 24'hFFFFFF);
      run_to(421);
      check("div3_frame1", fc_o[1], 1);
      run_to(461);
      check("solid_c0", dat_o[0][23:0], 24'h123456);
      check("solid_c1", dat_o[0][47:24], 24'h123456);
      run_to(470);
      check("sb_c0_drain", exp_q.size(), 0);

      // phase 2: reset on an active line, checkerboard then gradient
      phase    = 2;
      rst      = 1'b1;
      pat_mode = 2'd2;
      step();
      release_reset();
      run_to(1);
      check("rst_vsync_rise", vs_o[0], 1);
      check("rst_frame_zero", fc_o[0], 0);
      run_to(41);
      check("rst_x0", x_o[0], 0);
      check("rst_y0", y_o[0], 0);
      check("chk_c1_x0", dat_o[0][47:24], 24'h000000);
      run_to(44);
      check("chk_c0_x3", dat_o[0][23:0], 24'h000000);
      run_to(45);
      check("chk_c0_x4", dat_o[0][23:0], 24'hFFFFFF);
      check("chk_c1_x4", dat_o[0][47:24], 24'hFFFFFF);
      run_to(70);
      pat_mode = 2'd1;
      run_to(321);
      check("grad_f2_c0_x0", dat_o[0][23:0], MOTION ? 24'h020202 : 24'h000000);
      check("grad_f2_frame", fc_o[0], 2);
      run_to(430);
      check("sb_c0_final", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/video_pattern_src.md
Name: video_pattern_src

Overview:
- Synthesizable, parametrised successor to the behavioural BMP camera model.
- Generates NUM_CH time-aligned CMOS-style video streams (vsync/href/clken/data plus x/y position) from internal test patterns.
- Each channel sees a window onto one wide scene, offset horizontally by CH_X_OFFSET, so adjacent channels overlap as a stitching pair would.
- Drives the stitching top's cmos_* inputs on hardware and in simulation; no image file is required.

Parameters:
- NUM_CH, 2, number of output channels (1..4).
- COMP_W, 8, bits per colour component; pixel = 3*COMP_W, ordered R,G,B (MSB first).
- IMG_HDISP, 1280, active pixels per line.
- IMG_VDISP, 720, active lines per frame.
- H_BLANK, 160, blank pixel slots per line (>=1).
- V_SYNC, 5, lines with vsync high at frame start (>=1).
- V_BACK, 20, blank lines after vsync.
- V_FRONT, 5, blank lines after the last active line.
- CLK_DIV, 1, one pixel slot every CLK_DIV clocks (1..16).
- CH_X_OFFSET, 1024, scene x offset between adjacent channels.
- CELL_LOG2, 5, checkerboard cell size = 2**CELL_LOG2.

Ports:
- cmos_clk  in  1  clock.
- sys_rst  in  1  synchronous, active-high reset.
- pat_mode  in  2  0 colour bar, 1 gradient, 2 checkerboard, 3 solid.
- solid_rgb  in  3*COMP_W  colour used in mode 3.
- cmos_vsync  out  1  frame sync, high for the first V_SYNC lines.
- cmos_href  out  1  high during the active pixels of active lines.
- cmos_clken  out  1  pixel-valid strobe.
- cmos_data  out  NUM_CH*3*COMP_W  channel c occupies bits [c*3*COMP_W +: 3*COMP_W].
- x_pos  out  11  active pixel x (0..IMG_HDISP-1), valid with clken.
- y_pos  out  11  active line y (0..IMG_VDISP-1), valid with href.
- frame_cnt  out  16  completed-frame counter, wraps.

Behaviour:
- Reset: every output is 0; all counters are 0; the mode latch is 0 (colour bar).
- Slot tick: a divider counter pulses tick once every CLK_DIV cycles; tick is constant 1 when CLK_DIV=1. h_cnt and v_cnt advance only on tick.
- Horizontal: h_cnt runs 0..H_TOTAL-1 with H_TOTAL = IMG_HDISP+H_BLANK; on wrap, v_cnt increments.
- Vertical: v_cnt runs 0..V_TOTAL-1 with V_TOTAL = V_SYNC+V_BACK+IMG_VDISP+V_FRONT; on wrap, frame_cnt increments (mod 2**16).
- Active line: v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+IMG_VDISP); y = v_cnt-(V_SYNC+V_BACK).
- vsync = (v_cnt < V_SYNC). href = active line and h_cnt < IMG_HDISP, held across the non-tick cycles of a slot. clken = href & tick (one cycle per pixel).
- Latency: all outputs are registered together; 1 clock from the counter state to the outputs, with vsync/href/clken/data/x/y mutually aligned.
- cmos_data is 0 whenever clken=0.
- Mode latch: pat_mode and solid_rgb are sampled only when v_cnt=0, h_cnt=0 and tick=1. Mid-frame changes take effect at the next frame; there is no tearing.
- Scene x for channel c: xe = x + c*CH_X_OFFSET. Width is 13 bits internally; no wrap. FULL = all-ones COMP_W.
- Colour bar: 8 bars of width BAR_W = SCENE_W/8, where SCENE_W = IMG_HDISP+(NUM_CH-1)*CH_X_OFFSET. Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel uses a running bar counter preset at line start to its offset bar, not a divider. A remainder tail is black.
- Gradient: R=G=B = xe[COMP_W-1:0].
- Checkerboard: FULL grey when xe[CELL_LOG2] ^ y[CELL_LOG2] is set, else 0.
- Solid: the latched solid_rgb on all channels.
- Reset mid-frame: everything returns to the reset state the next cycle; the first vsync rises 1 cycle after sys_rst is released.

Optional Feature:
- Macro: VIDEO_PATTERN_SRC_MOTION_EN.
- Defined: xe additionally adds frame_cnt[7:0] (a scrolling pattern, per-frame shift of 1 pixel), applied to all channels equally; colour-bar counters are preset accordingly.
- Undefined: static pattern; frame_cnt is still output.

Decomposition:
- Package video_pattern_pkg: pat_mode_e enum, the 8 bar colour constants (generated from COMP_W), and timing-total localparam functions.
- One sub-module, video_timing_gen: divider, h/v counters, vsync/href/tick and frame_cnt. It is instantiated once; NUM_CH pattern slices are generated in a generate loop.

Test Plan:
Common settings for these tests: IMG_HDISP=16, IMG_VDISP=4, H_BLANK=4, V_SYNC=1, V_BACK=1, V_FRONT=1, NUM_CH=2, CH_X_OFFSET=8.
- Timing: CLK_DIV=1, release reset -> vsync high 20 cycles, 16 clken pulses per active line, 4 active lines, frame period 7*20=140 cycles, frame_cnt=1 at cycle 141.
- CLK_DIV=3 -> clken pulses are 3 cycles apart, href continuous for 48 cycles per line, frame period 420 cycles.
- Gradient -> channel 0 x=5 gives 0x050505, channel 1 x=5 gives 0x0D0D0D; data is 0 when clken=0.
- Colour bar (SCENE_W=24, BAR_W=3) -> channel 0 x=0 is 0xFFFFFF, x=3 is 0xFFFF00; channel 1 x=15 (xe=23) is 0x000000.
- Mode change mid-frame from 0 to 3 with solid_rgb=0x123456 -> rest of frame stays colour bar, next frame all pixels are 0x123456.
- Reset asserted on line 2 -> all outputs 0 the next cycle; after release, x/y restart at 0 and frame_cnt=0. With MOTION_EN, gradient at frame 2 (frame_cnt=2), x=0, channel 0 is 0x020202.
